// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types used by the result broadcast path.
//
// Contents:
//   cdb           - registered common-data-bus broadcast seen by every
//                   reservation station and the ROB (two lanes)
//   cdb_result_t  - one completed result waiting to be broadcast
//   cdb_src_t     - round-robin pointer for the shared lane 1
package rv32i_types;

    localparam int CDB_DATA_WIDTH    = 32;
    localparam int CDB_ROB_IDX_WIDTH = 5;
    localparam int REG_ADDR_WIDTH    = 5;

    typedef struct packed {
        logic                         alu_valid;
        logic [CDB_DATA_WIDTH-1:0]    alu_data;
        logic [REG_ADDR_WIDTH-1:0]    alu_rd_addr;
        logic [CDB_ROB_IDX_WIDTH-1:0] alu_rob_idx;
        logic                         mul_valid;
        logic [CDB_DATA_WIDTH-1:0]    mul_data;
        logic [REG_ADDR_WIDTH-1:0]    mul_rd_addr;
        logic [CDB_ROB_IDX_WIDTH-1:0] mul_rob_idx;
    } cdb;

    typedef struct packed {
        logic [CDB_DATA_WIDTH-1:0]    data;
        logic [REG_ADDR_WIDTH-1:0]    rd_addr;
        logic [CDB_ROB_IDX_WIDTH-1:0] rob_idx;
    } cdb_result_t;

    // Records which lane-1 source was granted most recently.
    typedef enum logic {
        SRC_MUL = 1'b0,
        SRC_MEM = 1'b1
    } cdb_src_t;

endpackage

// File: rtl/cdb_src_fifo.sv
// Small circular FIFO holding completed results for one CDB source.
//
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   flush        - drops every buffered entry at the next edge
//   push         - enqueue push_data (ignored when full or flushing)
//   push_data    - result to enqueue
//   pop          - discard the head entry (ignored when empty)
//   head         - oldest entry, valid when !empty
//   full, empty  - occupancy flags derived from the internal count
import rv32i_types::*;

module cdb_src_fifo #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        push,
    input  cdb_result_t push_data,
    input  logic        pop,
    output cdb_result_t head,
    output logic        full,
    output logic        empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    cdb_result_t            mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic                   do_push;
    logic                   do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; the count alone says which slots are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/cdb_broadcaster.sv
// Transmitter end of the common data bus. Buffers results from the ALU,
// mul/div and load/store units and broadcasts them on the registered cdbus.
// Lane 0 carries ALU results; lane 1 is shared by mul/div and load/store
// under round-robin arbitration.
//
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   flush             - mispredict flush, discards buffered and in-flight results
//   alu_res_*         - ALU result handshake (valid/ready) and payload
//   mul_res_*         - mul/div result handshake and payload
//   mem_res_*         - load/store result handshake and payload
//   cdbus             - registered two-lane broadcast
import rv32i_types::*;

module cdb_broadcaster #(
    parameter int FIFO_DEPTH    = 2,
    parameter int ROB_IDX_WIDTH = CDB_ROB_IDX_WIDTH,
    parameter int DATA_WIDTH    = CDB_DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,

    input  logic                     alu_res_valid,
    output logic                     alu_res_ready,
    input  logic [DATA_WIDTH-1:0]    alu_res_data,
    input  logic [4:0]               alu_res_rd_addr,
    input  logic [ROB_IDX_WIDTH-1:0] alu_res_rob_idx,

    input  logic                     mul_res_valid,
    output logic                     mul_res_ready,
    input  logic [DATA_WIDTH-1:0]    mul_res_data,
    input  logic [4:0]               mul_res_rd_addr,
    input  logic [ROB_IDX_WIDTH-1:0] mul_res_rob_idx,

    input  logic                     mem_res_valid,
    output logic                     mem_res_ready,
    input  logic [DATA_WIDTH-1:0]    mem_res_data,
    input  logic [4:0]               mem_res_rd_addr,
    input  logic [ROB_IDX_WIDTH-1:0] mem_res_rob_idx,

    output cdb                       cdbus
);

    cdb_result_t alu_in, mul_in, mem_in;
    cdb_result_t alu_head, mul_head, mem_head;
    cdb_result_t alu_cand, mul_cand, mem_cand;
    logic        alu_full, mul_full, mem_full;
    logic        alu_empty, mul_empty, mem_empty;
    logic        alu_accept, mul_accept, mem_accept;
    logic        alu_have, mul_have, mem_have;
    logic        mul_grant, mem_grant;
    logic        alu_push, mul_push, mem_push;
    logic        alu_pop, mul_pop, mem_pop;
    cdb_src_t    rr_ptr;

    assign alu_in = '{data: alu_res_data, rd_addr: alu_res_rd_addr, rob_idx: alu_res_rob_idx};
    assign mul_in = '{data: mul_res_data, rd_addr: mul_res_rd_addr, rob_idx: mul_res_rob_idx};
    assign mem_in = '{data: mem_res_data, rd_addr: mem_res_rd_addr, rob_idx: mem_res_rob_idx};

    // Ready looks only at occupancy, never at this cycle's dequeue, so a
    // full FIFO stalls its source for a cycle even if its head is leaving.
    assign alu_res_ready = !rst && !alu_full && !flush;
    assign mul_res_ready = !rst && !mul_full && !flush;
    assign mem_res_ready = !rst && !mem_full && !flush;

    assign alu_accept = alu_res_valid && alu_res_ready;
    assign mul_accept = mul_res_valid && mul_res_ready;
    assign mem_accept = mem_res_valid && mem_res_ready;

    // A source's candidate is its FIFO head, or the incoming result when the
    // FIFO is empty, which gives one-cycle latency through an idle path.
    always_comb begin
        alu_have  = !flush && (!alu_empty || alu_accept);
        mul_have  = !flush && (!mul_empty || mul_accept);
        mem_have  = !flush && (!mem_empty || mem_accept);
        alu_cand  = alu_empty ? alu_in : alu_head;
        mul_cand  = mul_empty ? mul_in : mul_head;
        mem_cand  = mem_empty ? mem_in : mem_head;

        // On contention the source that was not granted last wins.
        mul_grant = mul_have && (!mem_have || rr_ptr == SRC_MEM);
        mem_grant = mem_have && !mul_grant;

        // A granted bypass result goes straight out; anything else accepted
        // is queued behind the existing entries.
        alu_pop   = alu_have && !alu_empty;
        mul_pop   = mul_grant && !mul_empty;
        mem_pop   = mem_grant && !mem_empty;
        alu_push  = alu_accept && !alu_empty;
        mul_push  = mul_accept && !(mul_empty && mul_grant);
        mem_push  = mem_accept && !(mem_empty && mem_grant);
    end

    cdb_src_fifo #(.DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk(clk), .rst(rst), .flush(flush),
        .push(alu_push), .push_data(alu_in), .pop(alu_pop),
        .head(alu_head), .full(alu_full), .empty(alu_empty)
    );

    cdb_src_fifo #(.DEPTH(FIFO_DEPTH)) u_mul_fifo (
        .clk(clk), .rst(rst), .flush(flush),
        .push(mul_push), .push_data(mul_in), .pop(mul_pop),
        .head(mul_head), .full(mul_full), .empty(mul_empty)
    );

    cdb_src_fifo #(.DEPTH(FIFO_DEPTH)) u_mem_fifo (
        .clk(clk), .rst(rst), .flush(flush),
        .push(mem_push), .push_data(mem_in), .pop(mem_pop),
        .head(mem_head), .full(mem_full), .empty(mem_empty)
    );

    // Broadcast register and round-robin pointer. The pointer starts at mem
    // so mul wins the first contest, and it survives a flush because no
    // grant happens during one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cdbus  <= '0;
            rr_ptr <= SRC_MEM;
        end else begin
            cdbus.alu_valid   <= alu_have;
            cdbus.alu_data    <= alu_cand.data;
            cdbus.alu_rd_addr <= alu_cand.rd_addr;
            cdbus.alu_rob_idx <= alu_cand.rob_idx;
            cdbus.mul_valid   <= mul_grant || mem_grant;
            if (mul_grant) begin
                cdbus.mul_data    <= mul_cand.data;
                cdbus.mul_rd_addr <= mul_cand.rd_addr;
                cdbus.mul_rob_idx <= mul_cand.rob_idx;
                rr_ptr            <= SRC_MUL;
            end else if (mem_grant) begin
                cdbus.mul_data    <= mem_cand.data;
                cdbus.mul_rd_addr <= mem_cand.rd_addr;
                cdbus.mul_rob_idx <= mem_cand.rob_idx;
                rr_ptr            <= SRC_MEM;
            end
        end
    end

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Self-checking bench for cdb_broadcaster. A behavioural model of the
// per-source queues and round-robin pointer predicts each broadcast; the
// predictions are pushed to expected-output queues when stimulus is driven
// and popped when the DUT broadcasts.
import rv32i_types::*;

module tb_cdb_broadcaster;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        alu_res_valid, alu_res_ready;
    logic [31:0] alu_res_data;
    logic [4:0]  alu_res_rd_addr, alu_res_rob_idx;
    logic        mul_res_valid, mul_res_ready;
    logic [31:0] mul_res_data;
    logic [4:0]  mul_res_rd_addr, mul_res_rob_idx;
    logic        mem_res_valid, mem_res_ready;
    logic [31:0] mem_res_data;
    logic [4:0]  mem_res_rd_addr, mem_res_rob_idx;
    cdb          cdbus;

    cdb_broadcaster #(.FIFO_DEPTH(DEPTH), .ROB_IDX_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alu_res_valid(alu_res_valid), .alu_res_ready(alu_res_ready),
        .alu_res_data(alu_res_data), .alu_res_rd_addr(alu_res_rd_addr),
        .alu_res_rob_idx(alu_res_rob_idx),
        .mul_res_valid(mul_res_valid), .mul_res_ready(mul_res_ready),
        .mul_res_data(mul_res_data), .mul_res_rd_addr(mul_res_rd_addr),
        .mul_res_rob_idx(mul_res_rob_idx),
        .mem_res_valid(mem_res_valid), .mem_res_ready(mem_res_ready),
        .mem_res_data(mem_res_data), .mem_res_rd_addr(mem_res_rd_addr),
        .mem_res_rob_idx(mem_res_rob_idx),
        .cdbus(cdbus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: results buffered per source, pointer, expected broadcasts.
    cdb_result_t m_alu[$], m_mul[$], m_mem[$];
    cdb_result_t exp_alu[$], exp_l1[$];
    cdb_src_t    m_rr;
    int          seen_mul, seen_mem;
    logic        mem_stall_seen;

    localparam cdb_result_t Z = '0;

    function automatic cdb_result_t mk(input logic [31:0] d, input logic [4:0] rd,
                                       input logic [4:0] rob);
        cdb_result_t r;
        r.data    = d;
        r.rd_addr = rd;
        r.rob_idx = rob;
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] obs,
                               input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_alu.delete(); m_mul.delete(); m_mem.delete();
        exp_alu.delete(); exp_l1.delete();
        m_rr = SRC_MEM;
    endtask

    // Drives one cycle of stimulus, predicts the broadcast from the model,
    // then checks the DUT one time unit after the edge.
    task automatic applyStimulus(input logic av, input cdb_result_t ar,
                                 input logic mv, input cdb_result_t mr,
                                 input logic ev, input cdb_result_t er,
                                 input logic fl,
                                 output logic aacc, output logic macc, output logic eacc);
        logic ardy, mrdy, erdy, gm, ge;
        cdb_result_t e;
        alu_res_valid = av; alu_res_data = ar.data; alu_res_rd_addr = ar.rd_addr;
        alu_res_rob_idx = ar.rob_idx;
        mul_res_valid = mv; mul_res_data = mr.data; mul_res_rd_addr = mr.rd_addr;
        mul_res_rob_idx = mr.rob_idx;
        mem_res_valid = ev; mem_res_data = er.data; mem_res_rd_addr = er.rd_addr;
        mem_res_rob_idx = er.rob_idx;
        flush = fl;
        #1;
        ardy = (m_alu.size() < DEPTH) && !fl;
        mrdy = (m_mul.size() < DEPTH) && !fl;
        erdy = (m_mem.size() < DEPTH) && !fl;
        checkOutput("alu_ready", 128'(alu_res_ready), 128'(ardy));
        checkOutput("mul_ready", 128'(mul_res_ready), 128'(mrdy));
        checkOutput("mem_ready", 128'(mem_res_ready), 128'(erdy));
        if (ev && !mem_res_ready) mem_stall_seen = 1'b1;
        aacc = av && ardy;
        macc = mv && mrdy;
        eacc = ev && erdy;
        if (fl) begin
            m_alu.delete(); m_mul.delete(); m_mem.delete();
        end else begin
            if (aacc) m_alu.push_back(ar);
            if (macc) m_mul.push_back(mr);
            if (eacc) m_mem.push_back(er);
            if (m_alu.size() > 0) exp_alu.push_back(m_alu.pop_front());
            gm = (m_mul.size() > 0) && ((m_mem.size() == 0) || m_rr == SRC_MEM);
            ge = (m_mem.size() > 0) && !gm;
            if (gm) begin
                exp_l1.push_back(m_mul.pop_front());
                m_rr = SRC_MUL;
            end else if (ge) begin
                exp_l1.push_back(m_mem.pop_front());
                m_rr = SRC_MEM;
            end
        end
        @(posedge clk);
        #1;
        if (exp_alu.size() > 0) begin
            e = exp_alu.pop_front();
            checkOutput("alu_valid", 128'(cdbus.alu_valid), 128'(1));
            checkOutput("alu_data", 128'(cdbus.alu_data), 128'(e.data));
            checkOutput("alu_rd", 128'(cdbus.alu_rd_addr), 128'(e.rd_addr));
            checkOutput("alu_rob", 128'(cdbus.alu_rob_idx), 128'(e.rob_idx));
        end else begin
            checkOutput("alu_valid_idle", 128'(cdbus.alu_valid), 128'(0));
        end
        if (exp_l1.size() > 0) begin
            e = exp_l1.pop_front();
            checkOutput("mul_valid", 128'(cdbus.mul_valid), 128'(1));
            checkOutput("mul_data", 128'(cdbus.mul_data), 128'(e.data));
            checkOutput("mul_rd", 128'(cdbus.mul_rd_addr), 128'(e.rd_addr));
            checkOutput("mul_rob", 128'(cdbus.mul_rob_idx), 128'(e.rob_idx));
        end else begin
            checkOutput("mul_valid_idle", 128'(cdbus.mul_valid), 128'(0));
        end
        if (cdbus.mul_valid) begin
            if (cdbus.mul_rob_idx >= 5'd16) seen_mem++;
            else seen_mul++;
        end
    endtask

    task automatic idle(input int n);
        logic a, m, e;
        for (int i = 0; i < n; i++) applyStimulus(0, Z, 0, Z, 0, Z, 0, a, m, e);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic a, m, e;
        int mi, ei, cyc;

        rst = 1'b1; flush = 1'b0;
        alu_res_valid = 0; alu_res_data = 0; alu_res_rd_addr = 0; alu_res_rob_idx = 0;
        mul_res_valid = 0; mul_res_data = 0; mul_res_rd_addr = 0; mul_res_rob_idx = 0;
        mem_res_valid = 0; mem_res_data = 0; mem_res_rd_addr = 0; mem_res_rob_idx = 0;
        modelReset();
        seen_mul = 0; seen_mem = 0; mem_stall_seen = 1'b0;
        #12;
        checkOutput("reset_cdbus", 128'(cdbus), 128'(0));
        checkOutput("reset_alu_ready", 128'(alu_res_ready), 128'(0));
        checkOutput("reset_mul_ready", 128'(mul_res_ready), 128'(0));
        checkOutput("reset_mem_ready", 128'(mem_res_ready), 128'(0));
        rst = 1'b0;

        $display("[TB] single ALU result");
        applyStimulus(1, mk(32'hAA, 5, 3), 0, Z, 0, Z, 0, a, m, e);
        checkOutput("t1_alu_data", 128'(cdbus.alu_data), 128'h0AA);
        idle(1);

        $display("[TB] mul/mem contest after reset");
        applyStimulus(0, Z, 1, mk(7, 1, 1), 1, mk(9, 2, 2), 0, a, m, e);
        checkOutput("pair_first_mul", 128'(cdbus.mul_rob_idx), 128'(1));
        applyStimulus(0, Z, 1, mk(7, 1, 4), 1, mk(9, 2, 5), 0, a, m, e);
        checkOutput("pair_then_mem", 128'(cdbus.mul_rob_idx), 128'(2));
        idle(3);

        $display("[TB] ALU back-to-back, including rd 0");
        for (int i = 0; i < 4; i++)
            applyStimulus(1, mk(32'h100 + i, (i == 2) ? 5'd0 : 5'(i + 8), 5'(i)),
                          0, Z, 0, Z, 0, a, m, e);
        idle(1);

        $display("[TB] competing mul/mem streams");
        seen_mul = 0; seen_mem = 0; mi = 0; ei = 0; cyc = 0;
        while ((mi < 6 || ei < 6) && cyc < 60) begin
            applyStimulus(0, Z,
                          mi < 6, mk(32'h200 + mi, 5'(mi + 1), 5'(mi)),
                          ei < 6, mk(32'h300 + ei, 5'(ei + 10), 5'(16 + ei)),
                          0, a, m, e);
            if (m) mi++;
            if (e) ei++;
            cyc++;
        end
        checkOutput("stream_done", 128'(cyc < 60), 128'(1));
        idle(6);
        checkOutput("stream_mul_count", 128'(seen_mul), 128'(6));
        checkOutput("stream_mem_count", 128'(seen_mem), 128'(6));
        checkOutput("mem_ready_dropped", 128'(mem_stall_seen), 128'(1));

        $display("[TB] flush with queued results");
        for (int i = 0; i < 3; i++)
            applyStimulus(0, Z, 1, mk(32'h400 + i, 3, 5'(i + 6)),
                          1, mk(32'h500 + i, 4, 5'(i + 24)), 0, a, m, e);
        applyStimulus(1, mk(32'h66, 6, 9), 1, mk(32'h77, 7, 10),
                      1, mk(32'h88, 8, 28), 1, a, m, e);
        checkOutput("flush_no_accept", 128'({a, m, e}), 128'(0));
        checkOutput("flush_alu_valid", 128'(cdbus.alu_valid), 128'(0));
        checkOutput("flush_mul_valid", 128'(cdbus.mul_valid), 128'(0));
        applyStimulus(1, mk(32'h99, 9, 11), 1, mk(32'hAB, 1, 12),
                      1, mk(32'hCD, 2, 29), 0, a, m, e);
        idle(3);

        $display("[TB] asynchronous reset with results queued");
        for (int i = 0; i < 2; i++)
            applyStimulus(1, mk(32'h600 + i, 5, 5'(i)), 1, mk(32'h700 + i, 3, 5'(i + 13)),
                          1, mk(32'h800 + i, 4, 5'(i + 30)), 0, a, m, e);
        alu_res_valid = 0; mul_res_valid = 0; mem_res_valid = 0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_cdbus", 128'(cdbus), 128'(0));
        checkOutput("async_rst_alu_ready", 128'(alu_res_ready), 128'(0));
        checkOutput("async_rst_mul_ready", 128'(mul_res_ready), 128'(0));
        checkOutput("async_rst_mem_ready", 128'(mem_res_ready), 128'(0));
        modelReset();
        #1;
        rst = 1'b0;
        applyStimulus(0, Z, 1, mk(32'h11, 1, 14), 1, mk(32'h22, 2, 17), 0, a, m, e);
        checkOutput("post_rst_mul_first", 128'(cdbus.mul_rob_idx), 128'(14));
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
